// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
// Module   : down_counter_timer
// Desc     : Loadable down-counter timer with run/pause control and a
//            one-cycle terminal-count pulse. Define DOWN_COUNTER_RELOAD_EN
//            for auto-reload (periodic) mode; default build is one-shot.
// Revision : 1.0 - initial release
// ============================================================================
module down_counter_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] Q,
    output logic         tc,
    output logic         busy
);

`ifdef DOWN_COUNTER_RELOAD_EN
    localparam bit AUTO_RELOAD = 1'b1;
`else
    localparam bit AUTO_RELOAD = 1'b0;
`endif

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [W-1:0] reload_q, reload_d;
    logic         tc_q, tc_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            // Load beats everything, including a pending 1->0 step.
            count_d  = load_val;
            reload_d = load_val;
            if (load_val == '0) begin
                state_d = IDLE;
            end else if (en) begin
                state_d = RUN;
            end else begin
                state_d = PAUSE;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (!en) begin
                        state_d = PAUSE;
                    end else if (count_q == ONE) begin
                        count_d = '0;
                        tc_d    = 1'b1;
                        if (!AUTO_RELOAD) begin
                            state_d = IDLE;
                        end
                    end else if (count_q == '0) begin
                        // Only reachable in auto-reload mode, one edge after tc.
                        if (AUTO_RELOAD) begin
                            count_d = reload_q;
                        end
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                PAUSE: begin
                    if (en) begin
                        state_d = RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Q    = count_q;
    assign tc   = tc_q;
    assign busy = (state_q != IDLE);

endmodule
`default_nettype wire
